// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit_if
// Description : Bundle of the hazard-detection inputs and pipeline-control
//               outputs exchanged between the core pipeline and the
//               hazard_stall_unit.
//                 master : pipeline side, drives register indices and
//                          control bits, receives enables and flushes
//                 slave  : hazard_stall_unit side
// Ports (signals):
//   IF_ID_RegisterRs1/Rs2, IF_ID_UsesRs1/Rs2 : ID-stage source operands
//   ID_EX_RegisterRd, ID_EX_MemRead          : EX-stage destination / load
//   EX_BranchTaken                           : EX redirects the PC
//   EX_MEM_MemReq, dmem_ready                : MEM-stage access handshake
//   PCWrite, IF_ID_Write, EX_MEM_Write       : register enables
//   IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush   : bubble insertion
//   mem_error, stall_count                   : status / performance
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_RegisterRs1;
    logic [4:0]       IF_ID_RegisterRs2;
    logic             IF_ID_UsesRs1;
    logic             IF_ID_UsesRs2;
    logic [4:0]       ID_EX_RegisterRd;
    logic             ID_EX_MemRead;
    logic             EX_BranchTaken;
    logic             EX_MEM_MemReq;
    logic             dmem_ready;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Write;
    logic             MEM_WB_Flush;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
        output ID_EX_RegisterRd, ID_EX_MemRead, EX_BranchTaken,
        output EX_MEM_MemReq, dmem_ready,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
        input  EX_MEM_Write, MEM_WB_Flush, mem_error, stall_count
    );

    modport slave (
        input  IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
        input  ID_EX_RegisterRd, ID_EX_MemRead, EX_BranchTaken,
        input  EX_MEM_MemReq, dmem_ready,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
        output EX_MEM_Write, MEM_WB_Flush, mem_error, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Pipeline hazard control for the five-stage RV32 core.
//               Stalls on load-use dependences, freezes the pipeline while a
//               data-memory access is outstanding, squashes wrong-path
//               instructions after a taken branch, and raises a sticky error
//               when memory stays not-ready for MEM_TIMEOUT cycles.
// Ports       :
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous active-high reset
//   hz   - hazard_stall_unit_if.slave (hazard inputs, enables, flushes,
//          mem_error, stall_count)
// Parameters  :
//   MEM_TIMEOUT - consecutive not-ready cycles allowed before error (>=2)
//   CNT_W       - width of the saturating stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_stall_unit_if.slave hz
);

    localparam int                  c_WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0]    r_stall_count;

    logic w_mem_stall;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_count_stall;

    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_write;
    logic w_mem_wb_flush;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_mem_stall = hz.EX_MEM_MemReq & ~hz.dmem_ready;
    assign w_rs1_hit   = hz.IF_ID_UsesRs1 & (hz.IF_ID_RegisterRs1 == hz.ID_EX_RegisterRd);
    assign w_rs2_hit   = hz.IF_ID_UsesRs2 & (hz.IF_ID_RegisterRs2 == hz.ID_EX_RegisterRd);
    // x0 is hard-wired zero, so a load targeting it never creates a dependence.
    assign w_load_use  = hz.ID_EX_MemRead & (hz.ID_EX_RegisterRd != 5'd0) &
                         (w_rs1_hit | w_rs2_hit);

    // A load-use coinciding with a taken branch costs nothing: the dependent
    // instruction is squashed anyway.
    assign w_count_stall = (r_state != ST_ERROR) &
                           (w_mem_stall | (w_load_use & ~hz.EX_BranchTaken));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. wait_cnt holds the number of consecutive not-ready
    // cycles already seen, so reaching MEM_TIMEOUT-1 while still stalled
    // means this is the MEM_TIMEOUT-th one.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = c_WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + c_WAIT_ONE;
                    end
                end else begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mealy outputs. Reset forces the pipeline into a fully flushed,
    // frozen condition without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_write = 1'b1;
        w_mem_wb_flush = 1'b0;
        if (rst || (r_state == ST_ERROR)) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_mem_wb_flush = 1'b1;
        end else if (w_mem_stall) begin
            // Whole front of the pipeline holds; a branch in EX waits too.
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (hz.EX_BranchTaken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_flush  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_count_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign hz.PCWrite      = w_pc_write;
    assign hz.IF_ID_Write  = w_if_id_write;
    assign hz.IF_ID_Flush  = w_if_id_flush;
    assign hz.ID_EX_Flush  = w_id_ex_flush;
    assign hz.EX_MEM_Write = w_ex_mem_write;
    assign hz.MEM_WB_Flush = w_mem_wb_flush;
    assign hz.mem_error    = (r_state == ST_ERROR);
    assign hz.stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline control block for the five-stage RV32 core that handles every hazard the forwarding path cannot resolve. It stalls on load-use dependences and freezes the pipeline while a data-memory access is outstanding. It flushes the wrong-path instructions after a taken branch or jump, and reports a sticky error on a memory timeout. It takes register indices and control bits from the IF/ID and ID/EX pipeline registers and drives the write-enable and flush inputs of the PC and pipeline registers.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready cycles allowed before error (≥2)
- CNT_W, 16: width of stall performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- IF_ID_RegisterRs1  in  5  rs1 of instruction in ID
- IF_ID_RegisterRs2  in  5  rs2 of instruction in ID
- IF_ID_UsesRs1  in  1  ID instruction reads rs1
- IF_ID_UsesRs2  in  1  ID instruction reads rs2
- ID_EX_RegisterRd  in  5  rd of instruction in EX
- ID_EX_MemRead  in  1  EX instruction is a load
- EX_BranchTaken  in  1  branch/jump in EX redirects PC
- EX_MEM_MemReq  in  1  MEM-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  IF/ID loads a NOP
- ID_EX_Flush  out  1  ID/EX loads a bubble (control bits zero)
- EX_MEM_Write  out  1  ID/EX and EX/MEM register enable
- MEM_WB_Flush  out  1  MEM/WB loads a bubble
- mem_error  out  1  sticky timeout flag
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- State register: RUN, MEM_WAIT, ERROR. wait_cnt register: $clog2(MEM_TIMEOUT)+1 bits.
- mem_stall = EX_MEM_MemReq & ~dmem_ready.
- load_use = ID_EX_MemRead & (ID_EX_RegisterRd != 0) & ((IF_ID_UsesRs1 & Rs1 == Rd) | (IF_ID_UsesRs2 & Rs2 == Rd)).
- Default outputs (no hazard): PCWrite=1, IF_ID_Write=1, EX_MEM_Write=1, all flushes 0.
- Priority, highest first, in RUN or MEM_WAIT:
  - mem_stall: PCWrite=0, IF_ID_Write=0, EX_MEM_Write=0, MEM_WB_Flush=1. Nothing else flushed, so a simultaneous branch stays held in EX.
  - EX_BranchTaken: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1. The branch overrides load_use because the ID instruction is squashed.
  - load_use: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
- Transitions:
  - RUN → MEM_WAIT on mem_stall, with wait_cnt←1.
  - MEM_WAIT with mem_stall: if wait_cnt==MEM_TIMEOUT−1 → ERROR, otherwise wait_cnt+1.
  - MEM_WAIT without mem_stall → RUN with wait_cnt←0. The completing cycle uses the normal priority rules.
  - ERROR is terminal until rst. In ERROR: PCWrite=IF_ID_Write=EX_MEM_Write=0, all flushes=1, mem_error=1.
- stall_count increments on every non-ERROR cycle in which mem_stall or (load_use & ~EX_BranchTaken) is true. It saturates at all-ones.

## Timing
- Outputs are Mealy: combinational from the current inputs and registered state, and valid in the same cycle as the hazard. The pipeline registers act on the following edge.
- Load-use costs exactly one bubble. The next cycle, the load is in MEM and forwarding resolves the dependence.
- A memory access stalled for N cycles (N < MEM_TIMEOUT) freezes the pipeline for N cycles. It advances on the cycle dmem_ready=1.
- mem_error rises on the edge after the MEM_TIMEOUT-th consecutive not-ready cycle.
- While rst=1:
  - state=RUN, wait_cnt=0, stall_count=0, mem_error=0.
  - PCWrite=IF_ID_Write=EX_MEM_Write=0.
  - IF_ID_Flush=ID_EX_Flush=MEM_WB_Flush=1.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately (asynchronous). The first cycle after deassertion uses default outputs.
- Register x0 never creates a load-use hazard.

## Test plan
- Load-use: ID_EX_MemRead=1, Rd=5, Rs1=5, UsesRs1=1 for 1 cycle → PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, stall_count 0→1. Repeating with Rd=0 → defaults, count unchanged.
- Branch vs load-use: load_use true and EX_BranchTaken=1 → PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1, stall_count unchanged.
- Memory wait: EX_MEM_MemReq=1, dmem_ready=0 for 3 cycles then 1 (MEM_TIMEOUT=16) → EX_MEM_Write=0 and MEM_WB_Flush=1 for 3 cycles, normal on the 4th, stall_count=3, state back to RUN.
- Timeout: MEM_TIMEOUT=4, ready held 0 → mem_error=1 after 4th cycle edge. It stays 1 when ready rises; all enables 0.
- Reset mid-operation: assert rst during MEM_WAIT (wait_cnt=2) → all outputs at reset values within the same cycle, stall_count=0. After release, defaults.
- Saturation: CNT_W=4, 20 load-use cycles → stall_count holds 4'hF.
